ftseg_scan_ctrl: RTL

//  Time-multiplexed scan controller for a DIGITS-wide 14-segment display bank.

---
 rtl/ftseg_pkg.sv | 23 ++
 rtl/ftseg_scan_ctrl_if.sv | 24 ++
 rtl/ftseg_scan_tick.sv | 37 +++
 rtl/ftseg_scan_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ftseg_pkg.sv
// Shared types and constants for the 14-segment scan controller.
package ftseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         MAX_DIGITS = 32;

    // Active-low digit enables: all ones means every digit is dark.
    function automatic logic [MAX_DIGITS-1:0] CTL_ALL_OFF(input int n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ftseg_scan_ctrl_if.sv
// Frame-load handshake and display-drive bundle of the scan controller.
interface ftseg_scan_ctrl_if #(
    parameter int DIGITS = 4
) ();
    localparam int IDX_W = $clog2(DIGITS);

    logic                  enable;
    logic                  load_valid;
    logic [4*DIGITS-1:0]   load_data;
    logic                  load_ready;
    logic [3:0]            bcd_out;
    logic [DIGITS-1:0]     ftsd_ctl;
    logic [IDX_W-1:0]      scan_idx;

    modport master (
        output enable, load_valid, load_data,
        input  load_ready, bcd_out, ftsd_ctl, scan_idx
    );

    modport slave (
        input  enable, load_valid, load_data,
        output load_ready, bcd_out, ftsd_ctl, scan_idx
    );
endinterface

// File: rtl/ftseg_scan_tick.sv
// Refresh divider and guard-gap counter; pulses mark the last cycle of each phase.
module ftseg_scan_tick #(
    parameter int DIV_W     = 16,
    parameter int DIV_TERM  = 50000,
    parameter int GUARD_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_drive,
    input  logic in_guard,
    output logic drive_done,
    output logic guard_done
);
    localparam int GUARD_W    = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int GUARD_LAST = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;

    logic [DIV_W-1:0]   div;
    logic [GUARD_W-1:0] gcnt;

    assign drive_done = in_drive && (div == DIV_W'(DIV_TERM - 1));
    assign guard_done = in_guard && (gcnt == GUARD_W'(GUARD_LAST));

    // Counters wrap to zero on their own last cycle so the next phase starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            gcnt <= '0;
        end else if (clear) begin
            div  <= '0;
            gcnt <= '0;
        end else begin
            if (in_drive) div  <= drive_done ? '0 : div + 1'b1;
            if (in_guard) gcnt <= guard_done ? '0 : gcnt + 1'b1;
        end
    end
endmodule

// File: rtl/ftseg_scan_ctrl.sv
// Time-multiplexed digit scan controller with shadow frame and guard gap.
// Optional leading-zero suppression when FTSEG_LZ_BLANK_EN is defined.
module ftseg_scan_ctrl
    import ftseg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIV_W     = 16,
    parameter int DIV_TERM  = 50000,
    parameter int GUARD_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    ftseg_scan_ctrl_if.slave bus
);
    localparam int                    IDX_W     = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] CTL_OFF_W = CTL_ALL_OFF(DIGITS);
    localparam logic [DIGITS-1:0]     CTL_OFF   = CTL_OFF_W[DIGITS-1:0];

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_wrap;
    logic [4*DIGITS-1:0] active;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] frame_next;
    logic                pending;
    logic [3:0]          bcd_r;
    logic [DIGITS-1:0]   ctl_r;
    logic [DIGITS-1:0]   lz_blank;
    logic                drive_done;
    logic                guard_done;
    logic                clear;
    logic                accept;
    logic                commit;

    function automatic logic [DIGITS-1:0] drive_ctl(input logic [IDX_W-1:0] i);
        return ~(DIGITS'(1) << i);
    endfunction

    function automatic logic [3:0] digit_code(input logic [4*DIGITS-1:0] frame,
                                              input logic [IDX_W-1:0]    i,
                                              input logic [DIGITS-1:0]   blank);
        return blank[i] ? BLANK_CODE : frame[4*i +: 4];
    endfunction

    assign clear    = (state == IDLE) && bus.enable;
    assign idx_wrap = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    assign accept   = bus.load_valid && !pending;
    // Swap frames only between scan passes so one pass never mixes two loads.
    assign commit   = pending && ((state == IDLE) ||
                      ((state == DRIVE) && (idx == LAST_IDX) && (drive_done || !bus.enable)));
    assign frame_next = commit ? shadow : active;

    always_comb begin
        lz_blank = '0;
`ifdef FTSEG_LZ_BLANK_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (frame_next[4*i +: 4] != 4'h0) seen = 1'b1;
                lz_blank[i] = !seen;
            end
        end
`endif
    end

    ftseg_scan_tick #(
        .DIV_W     (DIV_W),
        .DIV_TERM  (DIV_TERM),
        .GUARD_CYC (GUARD_CYC)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_drive   (state == DRIVE),
        .in_guard   (state == GUARD),
        .drive_done (drive_done),
        .guard_done (guard_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            ctl_r   <= CTL_OFF;
            bcd_r   <= BLANK_CODE;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (commit) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= bus.load_data;
                pending <= 1'b1;
            end

            if (!bus.enable) begin
                state <= IDLE;
                idx   <= '0;
                ctl_r <= CTL_OFF;
                bcd_r <= BLANK_CODE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= DRIVE;
                        idx   <= '0;
                        ctl_r <= drive_ctl('0);
                        bcd_r <= digit_code(frame_next, '0, lz_blank);
                    end
                    DRIVE: begin
                        if (drive_done) begin
                            if (GUARD_CYC == 0) begin
                                idx   <= idx_wrap;
                                ctl_r <= drive_ctl(idx_wrap);
                                bcd_r <= digit_code(frame_next, idx_wrap, lz_blank);
                            end else begin
                                state <= GUARD;
                                ctl_r <= CTL_OFF;
                                bcd_r <= BLANK_CODE;
                            end
                        end
                    end
                    GUARD: begin
                        if (guard_done) begin
                            state <= DRIVE;
                            idx   <= idx_wrap;
                            ctl_r <= drive_ctl(idx_wrap);
                            bcd_r <= digit_code(frame_next, idx_wrap, lz_blank);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                        ctl_r <= CTL_OFF;
                        bcd_r <= BLANK_CODE;
                    end
                endcase
            end
        end
    end

    assign bus.load_ready = ~pending;
    assign bus.bcd_out    = bcd_r;
    assign bus.ftsd_ctl   = ctl_r;
    assign bus.scan_idx   = idx;
endmodule
